// File: rtl/avalon_ram_slave_if.sv
// Avalon-MM bus between the mips_cpu_bus master port and avalon_ram_slave.
// Signal names follow the Avalon-MM convention used by the CPU side.
interface avalon_ram_slave_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        fault;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, fault
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, fault
    );
endinterface

// File: rtl/avalon_ram_slave.sv
// Word-addressed, byte-enabled Avalon-MM RAM with programmable wait states.
// Optional AVL_RAM_FAULT_EN: out-of-range reads return DEADBEEF and set a sticky fault flag.
// The image preload is applied by the harness directly on r_mem.
module avalon_ram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    avalon_ram_slave_if.slave   avl
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_readdata;

    logic          w_req;
    logic [31:0]   w_idx;
    logic          w_addr_zero;
    logic          w_in_range;
    logic [AW-1:0] w_mem_idx;
    logic [31:0]   w_rd_word;
    logic          w_complete;
    logic          w_rd_capture;

    assign w_req       = avl.read | avl.write;
    assign w_idx       = (avl.address - BASE_ADDR) >> 2;
    assign w_addr_zero = (avl.address == 32'h0);
    assign w_in_range  = !w_addr_zero && (avl.address >= BASE_ADDR) && (w_idx < DEPTH_WORDS);
    assign w_mem_idx   = w_idx[AW-1:0];

`ifdef AVL_RAM_FAULT_EN
    localparam logic [31:0] OorData = 32'hDEADBEEF;
`else
    localparam logic [31:0] OorData = 32'h0;
`endif

    always_comb begin
        w_rd_word = 32'h0;
        if (w_in_range) begin
            w_rd_word = r_mem[w_mem_idx];
        end else if (!w_addr_zero) begin
            w_rd_word = OorData;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    if (WAIT_CYCLES > 0) begin
                        w_cnt_nxt   = WaitInit;
                        w_state_nxt = StWait;
                    end else begin
                        w_state_nxt = StAck;
                    end
                end
            end
            StWait: begin
                // A master dropping its request abandons the access.
                if (!w_req) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = StAck;
                    end
                end
            end
            StAck:   w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_complete   = (r_state == StAck) && w_req;
    assign w_rd_capture = (w_state_nxt == StAck) && avl.read && !avl.write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= 32'h0;
        end else if (w_rd_capture) begin
            r_readdata <= w_rd_word;
        end
    end

    // Memory has no reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (w_complete && avl.write && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (avl.byteenable[i]) begin
                    r_mem[w_mem_idx][8*i +: 8] <= avl.writedata[8*i +: 8];
                end
            end
        end
    end

`ifdef AVL_RAM_FAULT_EN
    logic r_fault;
    logic w_fault_set;

    // A plain read of address 0 is the CPU halt convention, not a fault.
    assign w_fault_set = w_complete && !w_in_range && !(w_addr_zero && !avl.write);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else if (w_fault_set) begin
            r_fault <= 1'b1;
        end
    end

    assign avl.fault = r_fault;
`else
    assign avl.fault = 1'b0;
`endif

    assign avl.waitrequest = w_req && (r_state != StAck);
    assign avl.readdata    = r_readdata;

endmodule

// File: tb/tb_avalon_ram_slave.sv
// Randomised scoreboard bench for avalon_ram_slave; builds with or without AVL_RAM_FAULT_EN.
module tb_avalon_ram_slave;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          DEPTH = 16;
    localparam int          WAITC = 2;
`ifdef AVL_RAM_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    avalon_ram_slave_if avl ();

    avalon_ram_slave #(
        .BASE_ADDR  (BASE),
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .avl  (avl)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rd;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    int          wcnt = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rd;
    bit          model_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        return (a != 32'h0) && (off >= 0) && ((off / 4) < DEPTH);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((longint'({32'h0, a}) - longint'({32'h0, BASE})) / 4);
    endfunction

    // Monitor: counts stall cycles of each request and checks the acknowledge cycle.
    always @(negedge clk) begin
        if (reset) begin
            wcnt = 0;
        end else if (avl.read || avl.write) begin
            if (avl.waitrequest) begin
                wcnt++;
            end else begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ack: got an acknowledge, expected none pending");
                end else begin
                    mon_e = sb.pop_front();
                    chk({mon_e.name, "_latency"}, 32'(wcnt), 32'(WAITC + 1));
                    chk({mon_e.name, "_readdata"}, avl.readdata, mon_e.rd);
                end
                wcnt = 0;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic idle();
        avl.read  = 1'b0;
        avl.write = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues one access, leaves it asserted after completion so calls can run back-to-back.
    task automatic xfer(input string name, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        exp_t e;
        bit   inr;
        int   n;
        inr = in_rng(a);
        if (wr) begin
            if (inr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model_mem[idx_of(a)][8*i +: 8] = wd[8*i +: 8];
                end
            end
        end else if (rd) begin
            if (inr)              model_rd = model_mem[idx_of(a)];
            else if (a == 32'h0)  model_rd = 32'h0;
            else                  model_rd = FAULT_EN ? 32'hDEADBEEF : 32'h0;
        end
        if (FAULT_EN && !inr && !(a == 32'h0 && !wr)) model_fault = 1'b1;
        e.name = name;
        e.rd   = model_rd;
        sb.push_back(e);
        avl.address    = a;
        avl.writedata  = wd;
        avl.byteenable = be;
        avl.read       = rd;
        avl.write      = wr;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!avl.waitrequest) break;
        end
        if (n == 50) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no acknowledge in 50 cycles, expected one", name);
            idle();
        end
        @(posedge clk);
        #1;
        chk({name, "_fault"}, 32'(avl.fault), 32'(model_fault));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] prev;
        time         t0;
        int          r;
        int          op;

        reset = 1'b1;
        avl.address = 32'h0;
        avl.writedata = 32'h0;
        avl.byteenable = 4'h0;
        idle();
        model_rd = 32'h0;
        model_fault = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("reset_readdata", avl.readdata, 32'h0);
        chk("reset_fault", 32'(avl.fault), 32'h0);
        chk("reset_waitrequest", 32'(avl.waitrequest), 32'h0);

        for (int i = 0; i < DEPTH; i++) begin
            xfer("init", 1'b0, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
        end
        xfer("init_w0", 1'b0, 1'b1, BASE, 32'h24020014, 4'hF);
        xfer("init_w1", 1'b0, 1'b1, BASE + 32'd4, 32'h11223344, 4'hF);
        xfer("pre_oor", 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF);
        idle();
        cycles(1);

        // Reset in the middle of a write's wait phase.
        avl.address = BASE;
        avl.writedata = 32'hFFFFFFFF;
        avl.byteenable = 4'hF;
        avl.write = 1'b1;
        cycles(1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_rd = 32'h0;
        model_fault = 1'b0;
        chk("t1_wait_follows_req", 32'(avl.waitrequest), 32'h1);
        chk("t1_readdata", avl.readdata, 32'h0);
        chk("t1_fault", 32'(avl.fault), 32'h0);
        cycles(1);
        idle();
        #1;
        chk("t1_wait_idle", 32'(avl.waitrequest), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        cycles(1);
        xfer("t5_zero_first", 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        idle();
        cycles(1);

        xfer("t2_read", 1'b1, 1'b0, BASE, 32'h0, 4'h0);
        idle();
        chk("t2_word", avl.readdata, 32'h24020014);
        cycles(1);

        xfer("t3_bytewr", 1'b0, 1'b1, BASE + 32'd4, 32'hAABBCCDD, 4'b0101);
        idle();
        cycles(1);
        xfer("t3_readback", 1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'hF);
        idle();
        chk("t3_word", avl.readdata, 32'h11BB33DD);
        cycles(1);

        t0 = $time;
        xfer("t4_wr", 1'b0, 1'b1, BASE + 32'd8, 32'h5A5A1234, 4'hF);
        xfer("t4_rd", 1'b1, 1'b0, BASE + 32'd8, 32'h0, 4'h0);
        chk("t4_b2b_time", 32'($time - t0), 32'(2 * (WAITC + 2) * 10));
        idle();
        chk("t4_word", avl.readdata, 32'h5A5A1234);
        cycles(1);

        xfer("t5_oor", 1'b1, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'hF);
        idle();
        chk("t5_oor_word", avl.readdata, FAULT_EN ? 32'hDEADBEEF : 32'h0);
        xfer("t5_zero", 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        idle();
        chk("t5_zero_word", avl.readdata, 32'h0);
        cycles(1);

        xfer("t6_rw", 1'b1, 1'b1, BASE + 32'd12, 32'hC0FFEE00, 4'hF);
        idle();
        chk("t6_rw_readdata", avl.readdata, 32'h0);
        xfer("t6_rw_check", 1'b1, 1'b0, BASE + 32'd12, 32'h0, 4'hF);
        idle();
        prev = model_rd;
        avl.address = BASE + 32'd16;
        avl.read = 1'b1;
        cycles(2);
        idle();
        cycles(1);
        chk("t6_drop_readdata", avl.readdata, prev);
        xfer("t6_after_drop", 1'b1, 1'b0, BASE + 32'd16, 32'h0, 4'hF);
        idle();
        cycles(1);

        for (int k = 0; k < 150; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
            else if (r == 7) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 3));
            else if (r == 8) a = 32'h0;
            else             a = BASE - 32'd4;
            op = int'($urandom_range(0, 3));
            xfer("rand", (op != 1), (op == 1 || op == 2), a, $urandom, 4'($urandom_range(0, 15)));
            r = int'($urandom_range(0, 2));
            if (r > 0) begin
                idle();
                cycles(r);
            end
        end
        idle();
        cycles(5);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
